// File: rtl/pipe_ctrl.sv
// pipe_ctrl - pipeline control unit sitting behind the execute stage.
//
// Redirects the PC on taken branches/jumps, flushes the IF/ID and ID/EX
// registers for a FLUSH_CYCLES-long window per taken jump, and stalls the
// front end on either the execute-stage hold flag or a granted external bus
// hold request (req/ack handshake).
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the jump and stall
// performance counters; without it both counter ports read 32'b0.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   jump_addr_i    jump target from execute stage
//   jump_en_i      taken branch/jump from execute stage
//   hold_flag_i    execute-stage stall request (level)
//   hold_req_i     external bus hold request (level, held until ack)
//   jump_addr_o    PC load value
//   jump_en_o      PC load enable
//   hold_pc_o      freeze PC
//   hold_if_id_o   freeze IF/ID register
//   hold_id_ex_o   freeze ID/EX register
//   flush_if_id_o  clear IF/ID register to NOP
//   flush_id_ex_o  clear ID/EX register to NOP
//   hold_ack_o     external hold granted (registered)
//   jump_cnt_o     taken-jump count
//   stall_cnt_o    stalled-cycle count
module pipe_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              jump_en_i,
  input  logic              hold_flag_i,
  input  logic              hold_req_i,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              jump_en_o,
  output logic              hold_pc_o,
  output logic              hold_if_id_o,
  output logic              hold_id_ex_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              hold_ack_o,
  output logic [31:0]       jump_cnt_o,
  output logic [31:0]       stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Number of cycles spent in FLUSH after the jump cycle itself; the jump
  // cycle already flushes combinationally, so the window totals FLUSH_CYCLES.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       jump_taken_s;
  logic       flush_s;
  logic       stall_s;

  // Jumps are ignored while the external hold is granted (EX is frozen).
  assign jump_taken_s = jump_en_i & (state_q != ST_HOLD);
  assign flush_s      = jump_taken_s | (state_q == ST_FLUSH);
  // Flush outranks any stall: a flushed register must not also be frozen.
  assign stall_s      = (hold_flag_i | (state_q == ST_HOLD)) & ~flush_s;

  assign jump_en_o     = jump_taken_s;
  assign jump_addr_o   = (state_q == ST_HOLD) ? {ADDR_W{1'b0}} : jump_addr_i;
  assign flush_if_id_o = flush_s;
  assign flush_id_ex_o = flush_s;
  assign hold_pc_o     = stall_s;
  assign hold_if_id_o  = stall_s;
  assign hold_id_ex_o  = stall_s;
  assign hold_ack_o    = ack_q;

  // Next-state logic for the RUN/FLUSH/HOLD controller and flush counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (jump_en_i) begin
          if (FLUSH_LOAD != 4'd0) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else begin
            // Single-cycle window: the jump cycle was the whole flush.
            state_d = hold_req_i ? ST_HOLD : ST_RUN;
            cnt_d   = 4'd0;
          end
        end else if (hold_req_i) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (jump_en_i && (FLUSH_LOAD != 4'd0)) begin
          // A new jump restarts the window.
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (cnt_q <= 4'd1) begin
          // Last flush cycle; a deferred bus request is granted now.
          state_d = hold_req_i ? ST_HOLD : ST_RUN;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_FLUSH;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (!hold_req_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign ack_d = (state_d == ST_HOLD);

  // State, flush counter and registered acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] jump_cnt_q;
  logic [31:0] stall_cnt_q;

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_cnt_q  <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      jump_cnt_q  <= jump_cnt_q + {31'd0, jump_taken_s};
      stall_cnt_q <= stall_cnt_q + {31'd0, stall_s};
    end
  end

  assign jump_cnt_o  = jump_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign jump_cnt_o  = 32'b0;
  assign stall_cnt_o = 32'b0;
`endif

endmodule
